// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the convolution controller.
// Holds the controller state encoding, the datapath sample width and
// the helper that sizes the tap index bus.
`timescale 1ns/1ps
package conv_pkg;

    localparam int ANCHO_DATO = 16;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        LIMPIA = 2'd1,
        MAC    = 2'd2,
        FIN    = 2'd3
    } estado_t;

    // Tap index width, never narrower than one bit (N_TAPS = 1 still needs a bus)
    function automatic int ancho_tap(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_tap.sv
// contador_tap: tap index counter for the MAC phase.
// Counts 0..N_TAPS-1, saturates at the last tap (never wraps), flags the
// last tap with ultimo. A synchronous clr has priority over inc.
`timescale 1ns/1ps
module contador_tap #(
    parameter int N_TAPS = 8,
    parameter int ANCHO  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [ANCHO-1:0] cuenta,
    output logic             ultimo
);

    localparam logic [ANCHO-1:0] C_ULTIMO = ANCHO'(N_TAPS - 1);
    localparam logic [ANCHO-1:0] C_UNO    = ANCHO'(1);

    logic [ANCHO-1:0] r_cuenta;

    // Tap counter: async clear on reset, sync clear, saturating increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cuenta <= '0;
        end else if (clr) begin
            r_cuenta <= '0;
        end else if (inc && !ultimo) begin
            r_cuenta <= r_cuenta + C_UNO;
        end
    end

    assign cuenta = r_cuenta;
    assign ultimo = (r_cuenta == C_ULTIMO);

endmodule

// File: rtl/control_conv.sv
// control_conv: sequencer for an N_TAPS multiply-accumulate convolution.
// Accepts one sample (shifting the sample chain on the handshake), clears
// the accumulator, steps sel_tap through every tap while accumulating,
// then presents the result until downstream takes it.
// Optional build macro CONTROL_CONV_CUENTA_EN adds cuenta_sal, a 16-bit
// wrapping count of consumed results.
`timescale 1ns/1ps
module control_conv
    import conv_pkg::*;
#(
    parameter int N_TAPS    = 8,
    parameter int ANCHO_TAP = ancho_tap(N_TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ent_valida,
    output logic                 ent_lista,
    output logic                 en_despl,
    output logic                 clr_acc,
    output logic                 en_acc,
    output logic [ANCHO_TAP-1:0] sel_tap,
    output logic                 sal_valida,
    input  logic                 sal_lista,
    output logic                 ocupado
`ifdef CONTROL_CONV_CUENTA_EN
    ,
    output logic [ANCHO_DATO-1:0] cuenta_sal
`endif
);

    estado_t              r_estado;
    estado_t              w_estado_sig;
    logic [ANCHO_TAP-1:0] w_cuenta;
    logic                 w_ultimo;
    logic                 w_clr_cnt;
    logic                 w_inc_cnt;

    // Counter is held at zero outside MAC and cleared on the last tap so
    // it is already back at zero when FIN is entered.
    assign w_inc_cnt = (r_estado == MAC);
    assign w_clr_cnt = (r_estado != MAC) || w_ultimo;

    contador_tap #(
        .N_TAPS (N_TAPS),
        .ANCHO  (ANCHO_TAP)
    ) u_contador_tap (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_clr_cnt),
        .inc    (w_inc_cnt),
        .cuenta (w_cuenta),
        .ultimo (w_ultimo)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next-state logic
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO:  if (ent_valida) w_estado_sig = LIMPIA;
            LIMPIA:  w_estado_sig = MAC;
            MAC:     if (w_ultimo) w_estado_sig = FIN;
            FIN:     if (sal_lista) w_estado_sig = REPOSO;
            default: w_estado_sig = REPOSO;
        endcase
    end

    // Output decode; en_despl is the combinational handshake so the sample
    // chain captures on the same edge the controller leaves REPOSO.
    always_comb begin
        ent_lista  = 1'b0;
        en_despl   = 1'b0;
        clr_acc    = 1'b0;
        en_acc     = 1'b0;
        sel_tap    = '0;
        sal_valida = 1'b0;
        ocupado    = 1'b1;
        case (r_estado)
            REPOSO: begin
                ent_lista = 1'b1;
                en_despl  = ent_valida;
                ocupado   = 1'b0;
            end
            LIMPIA: begin
                clr_acc = 1'b1;
            end
            MAC: begin
                en_acc  = 1'b1;
                sel_tap = w_cuenta;
            end
            FIN: begin
                sal_valida = 1'b1;
            end
            default: begin
                ocupado = 1'b1;
            end
        endcase
    end

`ifdef CONTROL_CONV_CUENTA_EN
    logic [ANCHO_DATO-1:0] r_cuenta_sal;

    // Consumed-result counter, wraps naturally at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cuenta_sal <= '0;
        end else if ((r_estado == FIN) && sal_lista) begin
            r_cuenta_sal <= r_cuenta_sal + 16'd1;
        end
    end

    assign cuenta_sal = r_cuenta_sal;
`endif

endmodule

// File: tb/tb_control_conv.sv
// tb_control_conv: directed bench for control_conv, N_TAPS=8 and N_TAPS=1.
// Outputs packed as {ent_lista,en_despl,clr_acc,en_acc,sal_valida,ocupado,sel_tap}.
`timescale 1ns/1ps
module tb_control_conv;

    logic       clk;
    logic       rst_n;
    logic       ev8, sl8;
    logic       ev1, sl1;

    logic       lista8, despl8, clr8, acc8, sval8, ocup8;
    logic [2:0] sel8;
    logic       lista1, despl1, clr1, acc1, sval1, ocup1;
    logic [0:0] sel1;

    int n_vec;
    int n_err;

`ifdef CONTROL_CONV_CUENTA_EN
    logic [15:0] cnt8, cnt1;
`endif

    control_conv #(.N_TAPS(8)) u8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ent_valida (ev8),
        .ent_lista  (lista8),
        .en_despl   (despl8),
        .clr_acc    (clr8),
        .en_acc     (acc8),
        .sel_tap    (sel8),
        .sal_valida (sval8),
        .sal_lista  (sl8),
        .ocupado    (ocup8)
`ifdef CONTROL_CONV_CUENTA_EN
        ,
        .cuenta_sal (cnt8)
`endif
    );

    control_conv #(.N_TAPS(1)) u1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .ent_valida (ev1),
        .ent_lista  (lista1),
        .en_despl   (despl1),
        .clr_acc    (clr1),
        .en_acc     (acc1),
        .sel_tap    (sel1),
        .sal_valida (sval1),
        .sal_lista  (sl1),
        .ocupado    (ocup1)
`ifdef CONTROL_CONV_CUENTA_EN
        ,
        .cuenta_sal (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic l, input logic d, input logic c,
                        input logic a, input logic v, input logic o, input logic [2:0] s);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {lista8, despl8, clr8, acc8, sval8, ocup8, sel8};
        exp = {l, d, c, a, v, o, s};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic l, input logic d, input logic c,
                        input logic a, input logic v, input logic o, input logic s);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {lista1, despl1, clr1, acc1, sval1, ocup1, sel1};
        exp = {l, d, c, a, v, o, s};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One complete 8-tap transaction with sal_lista high, starting in REPOSO
    task automatic run8(input string pre);
        ev8 = 1'b1;
        sl8 = 1'b1;
        #1 chk8({pre, "_hs"}, 1, 1, 0, 0, 0, 0, 3'd0);
        tick();
        ev8 = 1'b0;
        #1 chk8({pre, "_clr"}, 0, 0, 1, 0, 0, 1, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk8($sformatf("%s_mac%0d", pre, i), 0, 0, 0, 1, 0, 1, 3'(i));
        end
        tick();
        chk8({pre, "_fin"}, 0, 0, 0, 0, 1, 1, 3'd0);
        tick();
        chk8({pre, "_idle"}, 1, 0, 0, 0, 0, 0, 3'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        ev8 = 1'b0; sl8 = 1'b0;
        ev1 = 1'b0; sl1 = 1'b0;

        #3;
        chk8("rst8", 1, 0, 0, 0, 0, 0, 3'd0);
        chk1("rst1", 1, 0, 0, 0, 0, 0, 1'b0);
        #10 rst_n = 1'b1;
        tick();

        // Basic transaction: one shift, one clear, taps 0..7, one result cycle
        run8("t1");

        // Stall in FIN with ent_valida held high throughout
        ev8 = 1'b1;
        sl8 = 1'b0;
        #1 chk8("t2_hs", 1, 1, 0, 0, 0, 0, 3'd0);
        tick();
        chk8("t2_clr", 0, 0, 1, 0, 0, 1, 3'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk8($sformatf("t2_mac%0d", i), 0, 0, 0, 1, 0, 1, 3'(i));
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            chk8($sformatf("t2_stall%0d", k), 0, 0, 0, 0, 1, 1, 3'd0);
        end

        // Consume and offer a sample in the same FIN cycle: no bypass
        tick();
        sl8 = 1'b1;
        #1 chk8("t3_fin_both", 0, 0, 0, 0, 1, 1, 3'd0);
        tick();
        sl8 = 1'b0;
        #1 chk8("t3_reposo_hs", 1, 1, 0, 0, 0, 0, 3'd0);
        tick();
        ev8 = 1'b0;
        #1 chk8("t3_clr", 0, 0, 1, 0, 0, 1, 3'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk8($sformatf("t3_mac%0d", i), 0, 0, 0, 1, 0, 1, 3'(i));
        end

        // Asynchronous reset at sel_tap=3, between edges
        rst_n = 1'b0;
        #1 chk8("t4_rst_async", 1, 0, 0, 0, 0, 0, 3'd0);
        #3 rst_n = 1'b1;
        tick();
        chk8("t4_idle0", 1, 0, 0, 0, 0, 0, 3'd0);
        tick();
        chk8("t4_idle1", 1, 0, 0, 0, 0, 0, 3'd0);
        run8("t4");

        // sal_lista outside FIN is ignored: REPOSO stays idle
        sl8 = 1'b1;
        tick();
        chk8("t5_idle_sl", 1, 0, 0, 0, 0, 0, 3'd0);
        sl8 = 1'b0;

        // N_TAPS=1: one MAC cycle, result two cycles after the handshake
        ev1 = 1'b1;
        sl1 = 1'b1;
        #1 chk1("n1_hs", 1, 1, 0, 0, 0, 0, 1'b0);
        tick();
        ev1 = 1'b0;
        #1 chk1("n1_clr", 0, 0, 1, 0, 0, 1, 1'b0);
        tick();
        chk1("n1_mac0", 0, 0, 0, 1, 0, 1, 1'b0);
        tick();
        chk1("n1_fin", 0, 0, 0, 0, 1, 1, 1'b0);
        tick();
        chk1("n1_idle", 1, 0, 0, 0, 0, 0, 1'b0);

`ifdef CONTROL_CONV_CUENTA_EN
        n_vec++;
        assert (cnt8 === 16'd1) else begin
            n_err++;
            $error("FAIL cnt8 observed=%0d expected=%0d", cnt8, 1);
        end
        n_vec++;
        assert (cnt1 === 16'd1) else begin
            n_err++;
            $error("FAIL cnt1 observed=%0d expected=%0d", cnt1, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_conv.md
CONTROL_CONV -- requirements
Module: control_conv

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, number of convolution taps (legal range 1..64).
REQ-002 SHALL have parameter ANCHO_TAP, default $clog2(N_TAPS) with minimum 1, width of sel_tap.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ent_valida  in  1  new input sample present on the datapath ent bus.
REQ-006 SHALL have port ent_lista  out  1  controller accepts a sample this cycle.
REQ-007 SHALL have port en_despl  out  1  shift enable to the 16-bit sample register chain (registro_16 en pins).
REQ-008 SHALL have port clr_acc  out  1  synchronous clear of the accumulator.
REQ-009 SHALL have port en_acc  out  1  accumulate enable (sample[sel_tap]*coef[sel_tap]).
REQ-010 SHALL have port sel_tap  out  ANCHO_TAP  tap index for sample/coefficient muxes.
REQ-011 SHALL have port sal_valida  out  1  accumulator holds a finished result.
REQ-012 SHALL have port sal_lista  in  1  downstream consumes the result.
REQ-013 SHALL have port ocupado  out  1  high in any state other than REPOSO.

Function
REQ-014 SHALL implement FSM states REPOSO, LIMPIA, MAC, FIN.
REQ-015 In REPOSO: ent_lista=1. All other control outputs are 0.
REQ-016 en_despl SHALL equal ent_valida AND ent_lista, combinationally, so the register chain captures on the handshake edge.
REQ-017 REPOSO->LIMPIA on handshake; otherwise remain in REPOSO.
REQ-018 LIMPIA SHALL last exactly 1 cycle with clr_acc=1, sel_tap=0, then go to MAC.
REQ-019 MAC SHALL last exactly N_TAPS cycles with en_acc=1 and sel_tap=0,1,..,N_TAPS-1 in successive cycles, then go to FIN.
REQ-020 sel_tap SHALL never exceed N_TAPS-1 and SHALL NOT wrap within MAC. It SHALL be 0 outside MAC.
REQ-021 FIN SHALL hold sal_valida=1 with en_acc=0 until sal_lista=1. It SHALL go to REPOSO on the following edge.
REQ-022 Latency from the handshake edge to the first sal_valida cycle SHALL be N_TAPS+1 cycles.
REQ-023 ent_lista SHALL be 0 in LIMPIA, MAC and FIN. ent_valida in those states SHALL be ignored and cause no shift.
REQ-024 In FIN with sal_lista=1 and ent_valida=1 simultaneously: the result SHALL be consumed and the sample SHALL NOT be accepted. The sample is accepted in REPOSO one cycle later (no bypass).
REQ-025 sal_lista outside FIN SHALL have no effect.
REQ-026 N_TAPS=1 SHALL give exactly one MAC cycle with sel_tap=0.

Reset
REQ-027 rst_n=0 SHALL immediately force state REPOSO and tap counter 0, regardless of clk.
REQ-028 During reset, clr_acc, en_acc, sal_valida, ocupado and sel_tap SHALL be 0. en_despl SHALL be 0 when ent_valida=0.
REQ-029 Reset mid-MAC or mid-FIN SHALL abandon the result without a sal_valida pulse. After release, the first edge is in REPOSO.

Configuration
REQ-030 Macro CONTROL_CONV_CUENTA_EN defined SHALL add port cuenta_sal  out  16, the count of FIN->REPOSO transitions.
REQ-031 cuenta_sal SHALL reset to 0 and wrap 0xFFFF->0x0000.
REQ-032 Without CONTROL_CONV_CUENTA_EN, the port and the counter SHALL be absent. All other behaviour is identical.

Structure
REQ-033 Package conv_pkg SHALL hold the FSM state typedef (2-bit encoding REPOSO=0, LIMPIA=1, MAC=2, FIN=3) and ANCHO_DATO=16.
REQ-034 Sub-module contador_tap SHALL hold the tap counter: inputs clk, rst_n, clr, inc; output cuenta; parameter N_TAPS; terminal flag ultimo when cuenta==N_TAPS-1.

Verification
REQ-035 Reset, then one sample with N_TAPS=8 and sal_lista=1 -> en_despl 1 cycle, clr_acc 1 cycle, en_acc 8 cycles with sel_tap 0..7, sal_valida on edge 9 for 1 cycle.
REQ-036 sal_lista held 0 for 5 cycles in FIN -> sal_valida stays 1 for 5 cycles. ent_valida=1 throughout gives en_despl=0 and ent_lista=0.
REQ-037 sal_lista=1 and ent_valida=1 in the same FIN cycle -> REPOSO next cycle, en_despl=1 on that following cycle only.
REQ-038 rst_n pulsed low at sel_tap=3 -> outputs 0 at once, no sal_valida, and the next sample runs a complete 8-tap sequence.
REQ-039 N_TAPS=1 -> sal_valida 2 cycles after handshake. With CONTROL_CONV_CUENTA_EN and 65536 results, cuenta_sal returns to 0x0000.
